// File: rtl/neuron_update_scheduler.sv
// Timestep sequencer for the LIF accelerator: walks every neuron of a cluster,
// feeds the accelerator and writes its results back into the potential store.
`timescale 1ns/1ps
module neuron_update_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = 3,
  parameter int POT_W       = 32,
  parameter int ACC_LAT     = 1
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   start,
  input  logic [3:0]             spike_in,
  input  logic [POT_W-1:0]       v_threshold,
  input  logic [2:0]             decay_rate,
  input  logic                   cfg_we,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [POT_W-1:0]       cfg_wdata,
  output logic [ADDR_W-1:0]      w_addr,
  input  logic [127:0]           w_rdata,
  output logic [3:0]             acc_spike_in,
  output logic [127:0]           acc_weight,
  output logic [POT_W-1:0]       acc_v_threshold,
  output logic [POT_W-1:0]       acc_current_potential,
  output logic [2:0]             acc_decay_rate,
  input  logic                   acc_spiked,
  input  logic [POT_W-1:0]       acc_potential_to_mem,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spike_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int              CNT_W    = (ACC_LAT < 2) ? 1 : $clog2(ACC_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(ACC_LAT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  logic [2:0]             state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             spk_q, spk_d;
  logic [POT_W-1:0]       thr_q, thr_d;
  logic [2:0]             dec_q, dec_d;
  logic [NUM_NEURONS-1:0] work_q, work_d;
  logic [NUM_NEURONS-1:0] spike_out_q, spike_out_d;
  logic [ADDR_W-1:0]      w_addr_q, w_addr_d;
  logic [3:0]             acc_spk_q, acc_spk_d;
  logic [127:0]           acc_w_q, acc_w_d;
  logic [POT_W-1:0]       acc_thr_q, acc_thr_d;
  logic [POT_W-1:0]       acc_pot_q, acc_pot_d;
  logic [2:0]             acc_dec_q, acc_dec_d;
  logic [POT_W-1:0]       pot_q [NUM_NEURONS];

  logic                   pot_we;
  logic [ADDR_W-1:0]      pot_wa;
  logic [POT_W-1:0]       pot_wd;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    spk_d       = spk_q;
    thr_d       = thr_q;
    dec_d       = dec_q;
    work_d      = work_q;
    spike_out_d = spike_out_q;
    w_addr_d    = w_addr_q;
    acc_spk_d   = acc_spk_q;
    acc_w_d     = acc_w_q;
    acc_thr_d   = acc_thr_q;
    acc_pot_d   = acc_pot_q;
    acc_dec_d   = acc_dec_q;
    pot_we      = 1'b0;
    pot_wa      = cfg_addr;
    pot_wd      = cfg_wdata;
    case (state_q)
      S_IDLE: begin
        // Config write and start may coincide; the write lands before the walk reads.
        pot_we = cfg_we;
        if (start) begin
          spk_d    = spike_in;
          thr_d    = v_threshold;
          dec_d    = decay_rate;
          work_d   = '0;
          idx_d    = '0;
          w_addr_d = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        acc_w_d   = w_rdata;
        acc_pot_d = pot_q[idx_q];
        acc_spk_d = spk_q;
        acc_thr_d = thr_q;
        acc_dec_d = dec_q;
        cnt_d     = LAT_LD;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        pot_we        = 1'b1;
        pot_wa        = idx_q;
        pot_wd        = acc_potential_to_mem;
        work_d[idx_q] = acc_spiked;
        if (idx_q == LAST_IDX) begin
          // Publish together with the done pulse so both are visible in DONE.
          spike_out_d = work_d;
          state_d     = S_DONE;
        end else begin
          idx_d    = idx_q + ADDR_W'(1);
          w_addr_d = idx_q + ADDR_W'(1);
          state_d  = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      spk_q       <= '0;
      thr_q       <= '0;
      dec_q       <= '0;
      work_q      <= '0;
      spike_out_q <= '0;
      w_addr_q    <= '0;
      acc_spk_q   <= '0;
      acc_w_q     <= '0;
      acc_thr_q   <= '0;
      acc_pot_q   <= '0;
      acc_dec_q   <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      spk_q       <= spk_d;
      thr_q       <= thr_d;
      dec_q       <= dec_d;
      work_q      <= work_d;
      spike_out_q <= spike_out_d;
      w_addr_q    <= w_addr_d;
      acc_spk_q   <= acc_spk_d;
      acc_w_q     <= acc_w_d;
      acc_thr_q   <= acc_thr_d;
      acc_pot_q   <= acc_pot_d;
      acc_dec_q   <= acc_dec_d;
      if (pot_we) pot_q[pot_wa] <= pot_wd;
    end
  end

  assign w_addr                = w_addr_q;
  assign acc_spike_in          = acc_spk_q;
  assign acc_weight            = acc_w_q;
  assign acc_v_threshold       = acc_thr_q;
  assign acc_current_potential = acc_pot_q;
  assign acc_decay_rate        = acc_dec_q;
  assign busy                  = (state_q != S_IDLE);
  assign done                  = (state_q == S_DONE);
  assign spike_out             = spike_out_q;

endmodule
